// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and operation encoding for the carry-select adder
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK = 4;
  typedef enum logic {OP_ADD, OP_SUB} op_e;
endpackage

// File: rtl/cselect_block.sv
// cselect_block: one block computed for both carry-in values by two ripple adders
module cselect_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic [BLK-1:0] sum1,
  output logic           cout0,
  output logic           cout1
);
  logic [BLK:0] c0, c1;
  // ripple both carry assumptions side by side
  always_comb begin
    c0 = '0;
    c1 = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
    sum0 = a ^ b ^ c0[BLK-1:0];
    sum1 = a ^ b ^ c1[BLK-1:0];
  end
  assign cout0 = c0[BLK];
  assign cout1 = c1[BLK];
endmodule

// File: rtl/pipelined_cselect_adder.sv
// pipelined_cselect_adder: one carry-select block per stage, valid/ready with full-pipeline stall
module pipelined_cselect_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK = DEF_BLK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NBLK = WIDTH / BLK;
  localparam int MSB = WIDTH - 1;
  if (BLK < 1 || WIDTH % BLK != 0) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of BLK");
  end
  op_e op;
  logic stall;
  logic [WIDTH-1:0] a_q [NBLK];
  logic [WIDTH-1:0] b_q [NBLK];
  logic [WIDTH-1:0] s_q [NBLK];
  logic [WIDTH-1:0] nxt_s [NBLK];
  logic [BLK-1:0] s0 [NBLK];
  logic [BLK-1:0] s1 [NBLK];
  logic [NBLK-1:0] v_q, c_q, c0, c1, sel_c;
  assign op = in_sub ? OP_SUB : OP_ADD;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    cselect_block #(.BLK(BLK)) u_blk (
      .a(a_q[g][g*BLK +: BLK]),
      .b(b_q[g][g*BLK +: BLK]),
      .sum0(s0[g]),
      .sum1(s1[g]),
      .cout0(c0[g]),
      .cout1(c1[g])
    );
  end
  // pick each stage's block result by the carry it holds and merge it into the running sum
  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      nxt_s[k] = s_q[k];
      nxt_s[k][k*BLK +: BLK] = c_q[k] ? s1[k] : s0[k];
      sel_c[k] = c_q[k] ? c1[k] : c0[k];
    end
  end
  // advance every stage together unless the consumer is stalling the output
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      a_q[0] <= in_a;
      b_q[0] <= op == OP_SUB ? ~in_b : in_b;
      c_q[0] <= op == OP_SUB || in_cin;
      s_q[0] <= '0;
      for (int k = 1; k < NBLK; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        c_q[k] <= sel_c[k-1];
        s_q[k] <= nxt_s[k-1];
      end
      out_valid <= v_q[NBLK-1];
      if (v_q[NBLK-1]) begin
        out_sum <= nxt_s[NBLK-1];
        out_cout <= sel_c[NBLK-1];
        out_ovf <= a_q[NBLK-1][MSB] == b_q[NBLK-1][MSB] && nxt_s[NBLK-1][MSB] != a_q[NBLK-1][MSB];
      end
    end
endmodule

// File: tb/tb_pipelined_cselect_adder.sv
// tb_pipelined_cselect_adder: four configurations checked against an arithmetic scoreboard model
module tb_pipelined_cselect_adder;
  localparam int NI = 4;
  typedef struct {
    logic [31:0] sum;
    logic cout;
    logic ovf;
    int at;
  } exp_t;
  int wid [NI] = '{16, 8, 32, 8};
  int nb [NI] = '{4, 4, 4, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [NI], icin [NI], isub [NI], ordy [NI], irdy [NI], ov [NI], oc [NI], oo [NI];
  logic [31:0] ia [NI], ib [NI], os [NI];
  exp_t q [NI][$];
  int cnt [NI], nstall [NI], npop [NI], nacc [NI];
  logic pst [NI];
  logic [33:0] pv [NI];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = g == 0 ? 16 : g == 1 ? 8 : g == 2 ? 32 : 8;
    localparam int B = g == 0 ? 4 : g == 1 ? 2 : 8;
    logic [W-1:0] sum;
    pipelined_cselect_adder #(.WIDTH(W), .BLK(B)) dut (
      .clk(clk),
      .reset(rst),
      .in_valid(iv[g]),
      .in_ready(irdy[g]),
      .in_a(ia[g][W-1:0]),
      .in_b(ib[g][W-1:0]),
      .in_cin(icin[g]),
      .in_sub(isub[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_sum(sum),
      .out_cout(oc[g]),
      .out_ovf(oo[g])
    );
    assign os[g] = 32'(sum);
  end
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned au = a & m;
    longint unsigned bu = b & m;
    longint unsigned full = sub ? au - bu : au + bu + 64'(cin);
    longint lim = longint'(64'd1 << (w - 1));
    longint sa = au[w-1] ? longint'(au) - 2 * lim : longint'(au);
    longint sb = bu[w-1] ? longint'(bu) - 2 * lim : longint'(bu);
    longint sr = sub ? sa - sb : sa + sb + longint'(cin);
    exp_t e;
    e.sum = 32'(full & m);
    e.cout = sub ? au >= bu : full[w];
    e.ovf = sr < -lim || sr >= lim;
    e.at = 0;
    return e;
  endfunction
  function automatic logic [33:0] pack(exp_t e);
    return {e.sum, e.cout, e.ovf};
  endfunction
  task automatic check();
    for (int g = 0; g < NI; g++) begin
      logic st;
      exp_t e;
      if (rst) begin
        q[g].delete();
        pst[g] = 1'b0;
        continue;
      end
      st = ov[g] && !ordy[g];
      chk($sformatf("in_ready[%0d]", g), 64'(irdy[g]), 64'(!st));
      if (pst[g]) chk($sformatf("hold[%0d]", g), 64'({os[g], oc[g], oo[g]}), 64'(pv[g]));
      if (q[g].size() > 0 && q[g][0].at + nb[g] == cnt[g]) chk($sformatf("due[%0d]", g), 64'(ov[g]), 64'(1));
      if (ov[g] && ordy[g]) begin
        chk($sformatf("nonempty[%0d]", g), 64'(q[g].size() > 0), 64'(1));
        if (q[g].size() > 0) begin
          e = q[g].pop_front();
          chk($sformatf("result[%0d]", g), 64'({os[g], oc[g], oo[g]}), 64'(pack(e)));
          chk($sformatf("latency[%0d]", g), 64'(cnt[g] - e.at), 64'(nb[g]));
          npop[g]++;
        end
      end
      if (iv[g] && irdy[g]) begin
        e = model(wid[g], ia[g], ib[g], icin[g], isub[g]);
        e.at = cnt[g] + 1;
        q[g].push_back(e);
        nacc[g]++;
      end
      if (st) nstall[g]++;
      else cnt[g]++;
      pst[g] = st;
      pv[g] = {os[g], oc[g], oo[g]};
    end
  endtask
  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int g, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    iv[g] = 1'b1;
    ia[g] = a;
    ib[g] = b;
    icin[g] = cin;
    isub[g] = sub;
  endtask
  initial begin
    int base_pop, base_stall, base_acc, sent, hold, cyc;
    int start [NI];
    logic trig, done;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; ordy[g] = 1'b1; ia[g] = '0; ib[g] = '0; icin[g] = 1'b0; isub[g] = 1'b0;
      cnt[g] = 0; nstall[g] = 0; npop[g] = 0; nacc[g] = 0; pst[g] = 1'b0; pv[g] = '0;
    end
    chk("pin_ffff_plus_1", 64'(pack(model(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0))), 64'({32'h0000, 1'b1, 1'b0}));
    chk("pin_7fff_plus_1", 64'(pack(model(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0))), 64'({32'h8000, 1'b0, 1'b1}));
    chk("pin_5_minus_7", 64'(pack(model(16, 32'h0005, 32'h0007, 1'b0, 1'b1))), 64'({32'hFFFE, 1'b0, 1'b0}));
    chk("pin_8000_minus_1", 64'(pack(model(16, 32'h8000, 32'h0001, 1'b0, 1'b1))), 64'({32'h7FFF, 1'b1, 1'b1}));
    chk("pin_8b_cin", 64'(pack(model(8, 32'h7F, 32'h00, 1'b1, 1'b0))), 64'({32'h80, 1'b0, 1'b1}));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov[0]), 64'(0));
    chk("reset_out_sum", 64'({os[0], oc[0], oo[0]}), 64'(0));
    chk("reset_in_ready", 64'(irdy[0]), 64'(1));
    rst = 1'b0;
    drive(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    step();
    drive(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    step();
    drive(0, 32'h0005, 32'h0007, 1'b1, 1'b1);
    step();
    drive(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
    step();
    iv[0] = 1'b0;
    repeat (6) step();
    chk("directed_count", 64'(npop[0]), 64'(4));
    base_pop = npop[0]; base_stall = nstall[0]; base_acc = nacc[0];
    sent = 0; hold = 0; trig = 1'b0; cyc = 0;
    while (npop[0] - base_pop < 8 && cyc < 60) begin
      ordy[0] = hold == 0;
      if (hold > 0) hold--;
      if (sent < 8) drive(0, 32'($urandom_range(0, 16'hFFFF)), 32'($urandom_range(0, 16'hFFFF)), 1'($urandom), 1'($urandom));
      else iv[0] = 1'b0;
      step();
      sent = nacc[0] - base_acc;
      if (npop[0] - base_pop == 2 && !trig) begin
        trig = 1'b1;
        hold = 3;
      end
      cyc++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("stream_results", 64'(npop[0] - base_pop), 64'(8));
    chk("stream_stall_cycles", 64'(nstall[0] - base_stall), 64'(3));
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h1234 + 32'(i), 32'h0F0F, 1'b0, 1'(i));
      step();
    end
    iv[0] = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(ov[0]), 64'(0));
    chk("async_reset_out_data", 64'({os[0], oc[0], oo[0]}), 64'(0));
    chk("async_reset_in_ready", 64'(irdy[0]), 64'(1));
    step();
    step();
    rst = 1'b0;
    base_pop = npop[0];
    repeat (6) step();
    chk("no_stale_result", 64'(npop[0] - base_pop), 64'(0));
    drive(0, 32'hABCD, 32'h1111, 1'b1, 1'b0);
    step();
    iv[0] = 1'b0;
    repeat (6) step();
    chk("post_reset_result", 64'(npop[0] - base_pop), 64'(1));
    for (int g = 0; g < NI; g++) start[g] = nacc[g];
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20000) begin
      for (int g = 0; g < NI; g++) begin
        iv[g] = nacc[g] - start[g] < 1000 && $urandom_range(0, 3) != 0;
        ia[g] = $urandom;
        ib[g] = $urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : $urandom;
        icin[g] = 1'($urandom);
        isub[g] = 1'($urandom);
        ordy[g] = $urandom_range(0, 3) != 0;
      end
      step();
      done = 1'b1;
      for (int g = 0; g < NI; g++) if (nacc[g] - start[g] < 1000) done = 1'b0;
      cyc++;
    end
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0;
      ordy[g] = 1'b1;
    end
    repeat (10) step();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("random_accepted[%0d]", g), 64'(nacc[g] - start[g]), 64'(1000));
      chk($sformatf("random_drained[%0d]", g), 64'(q[g].size()), 64'(0));
      chk($sformatf("random_balance[%0d]", g), 64'(npop[g]), 64'(nacc[g] - 1 * (g == 0 ? 3 : 0)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
